// File: rtl/afe_ro_udma_rx_if.sv
// AFE readout read-side uDMA bridge: forwards AFE L2 reads to a uDMA TX channel.
// Response slots are reserved at grant time, so returning data always finds space.
module afe_ro_udma_rx_if #(
    parameter int unsigned L2_DATA_WIDTH  = 32,
    parameter int unsigned L2_AWIDTH_NOAL = 12,
    parameter int unsigned RESP_DEPTH     = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      test_mode_i,
    input  logic                      udma_shtdwn_i,
    input  logic                      afero_req_i,
    output logic                      afero_gnt_o,
    input  logic [L2_AWIDTH_NOAL-1:0] afero_addr_i,
    input  logic [1:0]                afero_size_i,
    output logic                      afero_rvalid_o,
    input  logic                      afero_rready_i,
    output logic [L2_DATA_WIDTH-1:0]  afero_rdata_o,
    output logic                      afero_idle_o,
    output logic                      udma_req_o,
    input  logic                      udma_gnt_i,
    output logic [L2_AWIDTH_NOAL-1:0] udma_addr_o,
    output logic [1:0]                udma_size_o,
    input  logic                      udma_valid_i,
    output logic                      udma_ready_o,
    input  logic [L2_DATA_WIDTH-1:0]  udma_data_i,
    output logic                      err_o
);

    localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
    localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e                    r_state;
    state_e                    w_state_nxt;
    logic [CW-1:0]             r_inflight;
    logic [CW-1:0]             w_inflight_nxt;
    logic [CW-1:0]             r_usage;
    logic [CW-1:0]             w_usage_nxt;
    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    logic [PW-1:0]             w_wptr_inc;
    logic [PW-1:0]             w_rptr_inc;
    logic [L2_DATA_WIDTH-1:0]  r_mem [RESP_DEPTH];
    logic [L2_AWIDTH_NOAL-1:0] r_addr;
    logic [1:0]                r_size;
    logic                      r_err;
    logic [CW:0]               w_used;
    logic                      w_credit_ok;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic                      w_grant;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_spurious;
    logic                      w_unused;

    // No internal clock gating is implemented, so test mode has no effect here.
    assign w_unused = test_mode_i;

    // Credits are derived only from registered occupancy terms.
    assign w_used       = {1'b0, r_inflight} + {1'b0, r_usage};
    assign w_credit_ok  = (w_used < (CW + 1)'(RESP_DEPTH));
    assign w_fifo_full  = (r_usage == CW'(RESP_DEPTH));
    assign w_fifo_empty = (r_usage == {CW{1'b0}});

    assign w_push     = udma_valid_i & ~w_fifo_full & (r_inflight != {CW{1'b0}});
    assign w_spurious = udma_valid_i & (r_inflight == {CW{1'b0}});
    assign w_pop      = ~w_fifo_empty & afero_rready_i;

    assign w_wptr_inc = (r_wptr == PW'(RESP_DEPTH - 1)) ? {PW{1'b0}} : r_wptr + PW'(1);
    assign w_rptr_inc = (r_rptr == PW'(RESP_DEPTH - 1)) ? {PW{1'b0}} : r_rptr + PW'(1);

    // Request FSM next state and AFE grant decode.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (afero_req_i && !udma_shtdwn_i && w_credit_ok) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (udma_gnt_i) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // In-flight and FIFO occupancy counters.
    always_comb begin
        w_inflight_nxt = r_inflight;
        w_usage_nxt    = r_usage;
        case ({w_grant, w_push})
            2'b10:   w_inflight_nxt = r_inflight + CW'(1);
            2'b01:   w_inflight_nxt = r_inflight - CW'(1);
            default: w_inflight_nxt = r_inflight;
        endcase
        case ({w_push, w_pop})
            2'b10:   w_usage_nxt = r_usage + CW'(1);
            2'b01:   w_usage_nxt = r_usage - CW'(1);
            default: w_usage_nxt = r_usage;
        endcase
    end

    // State, counters, latched request and sticky error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_inflight <= {CW{1'b0}};
            r_usage    <= {CW{1'b0}};
            r_wptr     <= {PW{1'b0}};
            r_rptr     <= {PW{1'b0}};
            r_addr     <= {L2_AWIDTH_NOAL{1'b0}};
            r_size     <= 2'b00;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_inflight_nxt;
            r_usage    <= w_usage_nxt;
            if (w_push) begin
                r_wptr <= w_wptr_inc;
            end
            if (w_pop) begin
                r_rptr <= w_rptr_inc;
            end
            if (w_grant) begin
                r_addr <= afero_addr_i;
                r_size <= afero_size_i;
            end
            if (w_spurious) begin
                r_err <= 1'b1;
            end
        end
    end

    // Response storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < RESP_DEPTH; i++) begin
                r_mem[i] <= {L2_DATA_WIDTH{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= udma_data_i;
        end
    end

    assign afero_gnt_o    = w_grant;
    assign afero_rvalid_o = ~w_fifo_empty;
    assign afero_rdata_o  = r_mem[r_rptr];
    assign afero_idle_o   = (r_state == ST_IDLE) & (r_inflight == {CW{1'b0}}) & w_fifo_empty;
    assign udma_req_o     = (r_state == ST_REQ);
    assign udma_addr_o    = r_addr;
    assign udma_size_o    = r_size;
    assign udma_ready_o   = ~w_fifo_full;
    assign err_o          = r_err;

endmodule

// File: tb/tb_afe_ro_udma_rx_if.sv
// Directed self-checking bench for afe_ro_udma_rx_if (default parameters, RESP_DEPTH=2).
module tb_afe_ro_udma_rx_if;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        test_mode_i;
    logic        udma_shtdwn_i;
    logic        afero_req_i;
    logic        afero_gnt_o;
    logic [11:0] afero_addr_i;
    logic [1:0]  afero_size_i;
    logic        afero_rvalid_o;
    logic        afero_rready_i;
    logic [31:0] afero_rdata_o;
    logic        afero_idle_o;
    logic        udma_req_o;
    logic        udma_gnt_i;
    logic [11:0] udma_addr_o;
    logic [1:0]  udma_size_o;
    logic        udma_valid_i;
    logic        udma_ready_o;
    logic [31:0] udma_data_i;
    logic        err_o;

    int checks   = 0;
    int failures = 0;
    int grants;

    afe_ro_udma_rx_if dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .test_mode_i    (test_mode_i),
        .udma_shtdwn_i  (udma_shtdwn_i),
        .afero_req_i    (afero_req_i),
        .afero_gnt_o    (afero_gnt_o),
        .afero_addr_i   (afero_addr_i),
        .afero_size_i   (afero_size_i),
        .afero_rvalid_o (afero_rvalid_o),
        .afero_rready_i (afero_rready_i),
        .afero_rdata_o  (afero_rdata_o),
        .afero_idle_o   (afero_idle_o),
        .udma_req_o     (udma_req_o),
        .udma_gnt_i     (udma_gnt_i),
        .udma_addr_o    (udma_addr_o),
        .udma_size_o    (udma_size_o),
        .udma_valid_i   (udma_valid_i),
        .udma_ready_o   (udma_ready_o),
        .udma_data_i    (udma_data_i),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_udma_req"}, {31'd0, udma_req_o}, 32'd0);
        chk({tag, "_udma_addr"}, {20'd0, udma_addr_o}, 32'd0);
        chk({tag, "_udma_size"}, {30'd0, udma_size_o}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, afero_rvalid_o}, 32'd0);
        chk({tag, "_gnt"}, {31'd0, afero_gnt_o}, 32'd0);
        chk({tag, "_idle"}, {31'd0, afero_idle_o}, 32'd1);
        chk({tag, "_err"}, {31'd0, err_o}, 32'd0);
        chk({tag, "_ready"}, {31'd0, udma_ready_o}, 32'd1);
    endtask

    initial begin
        rst_ni         = 1'b0;
        test_mode_i    = 1'b0;
        udma_shtdwn_i  = 1'b0;
        afero_req_i    = 1'b0;
        afero_addr_i   = 12'h000;
        afero_size_i   = 2'd0;
        afero_rready_i = 1'b0;
        udma_gnt_i     = 1'b0;
        udma_valid_i   = 1'b0;
        udma_data_i    = 32'h0;
        #12;
        chk_reset_outputs("rst");
        rst_ni = 1'b1;
        tick();

        // Single read with a uDMA grant on the third request cycle.
        afero_req_i  = 1'b1;
        afero_addr_i = 12'h010;
        afero_size_i = 2'd2;
        #1;
        chk("single_gnt", {31'd0, afero_gnt_o}, 32'd1);
        tick();
        afero_req_i  = 1'b0;
        afero_addr_i = 12'hFFF;
        for (int k = 0; k < 3; k++) begin
            udma_gnt_i = (k == 2);
            #1;
            chk("single_req_held", {31'd0, udma_req_o}, 32'd1);
            chk("single_addr", {20'd0, udma_addr_o}, 32'h010);
            tick();
        end
        udma_gnt_i = 1'b0;
        #1;
        chk("single_req_drop", {31'd0, udma_req_o}, 32'd0);
        udma_valid_i = 1'b1;
        udma_data_i  = 32'hCAFEF00D;
        #1;
        chk("single_ready", {31'd0, udma_ready_o}, 32'd1);
        chk("single_rvalid_pre", {31'd0, afero_rvalid_o}, 32'd0);
        tick();
        udma_valid_i = 1'b0;
        #1;
        chk("single_rvalid", {31'd0, afero_rvalid_o}, 32'd1);
        chk("single_rdata", afero_rdata_o, 32'hCAFEF00D);
        chk("single_busy", {31'd0, afero_idle_o}, 32'd0);
        afero_rready_i = 1'b1;
        tick();
        afero_rready_i = 1'b0;
        #1;
        chk("single_popped", {31'd0, afero_rvalid_o}, 32'd0);
        chk("single_idle", {31'd0, afero_idle_o}, 32'd1);

        // Credit stall: requests held continuously, only two may be granted.
        afero_req_i  = 1'b1;
        afero_addr_i = 12'h020;
        udma_gnt_i   = 1'b1;
        grants       = 0;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (afero_gnt_o) grants++;
            tick();
        end
        chk("credit_grants", grants, 32'd2);
        udma_gnt_i   = 1'b0;
        udma_valid_i = 1'b1;
        udma_data_i  = 32'h11111111;
        tick();
        udma_data_i  = 32'h22222222;
        tick();
        udma_valid_i = 1'b0;
        #1;
        chk("credit_stall_gnt", {31'd0, afero_gnt_o}, 32'd0);

        // Back-pressure: head stays put while rready is low.
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("bp_rvalid", {31'd0, afero_rvalid_o}, 32'd1);
            chk("bp_head", afero_rdata_o, 32'h11111111);
            chk("bp_no_gnt", {31'd0, afero_gnt_o}, 32'd0);
            tick();
        end
        afero_rready_i = 1'b1;
        #1;
        chk("pop_gnt_pre", {31'd0, afero_gnt_o}, 32'd0);
        tick();
        afero_rready_i = 1'b0;
        #1;
        chk("pop_gnt_post", {31'd0, afero_gnt_o}, 32'd1);
        chk("pop_order", afero_rdata_o, 32'h22222222);
        tick();
        afero_req_i = 1'b0;

        // Shutdown during REQ keeps the request up until granted.
        udma_shtdwn_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("shdn_req_held", {31'd0, udma_req_o}, 32'd1);
            chk("shdn_addr", {20'd0, udma_addr_o}, 32'h020);
            tick();
        end
        udma_gnt_i = 1'b1;
        tick();
        udma_gnt_i  = 1'b0;
        afero_req_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("shdn_no_gnt", {31'd0, afero_gnt_o}, 32'd0);
            chk("shdn_req_low", {31'd0, udma_req_o}, 32'd0);
            tick();
        end
        udma_valid_i = 1'b1;
        udma_data_i  = 32'h33333333;
        tick();
        udma_valid_i   = 1'b0;
        afero_rready_i = 1'b1;
        #1;
        chk("shdn_head0", afero_rdata_o, 32'h22222222);
        tick();
        #1;
        chk("shdn_head1", afero_rdata_o, 32'h33333333);
        chk("shdn_gnt_still0", {31'd0, afero_gnt_o}, 32'd0);
        tick();
        afero_rready_i = 1'b0;
        #1;
        chk("shdn_drained", {31'd0, afero_rvalid_o}, 32'd0);
        chk("shdn_idle", {31'd0, afero_idle_o}, 32'd1);
        afero_req_i   = 1'b0;
        udma_shtdwn_i = 1'b0;

        // Spurious response with nothing in flight.
        chk("spur_err_pre", {31'd0, err_o}, 32'd0);
        udma_valid_i = 1'b1;
        udma_data_i  = 32'hDEADBEEF;
        tick();
        udma_valid_i = 1'b0;
        #1;
        chk("spur_err", {31'd0, err_o}, 32'd1);
        chk("spur_rvalid", {31'd0, afero_rvalid_o}, 32'd0);
        chk("spur_idle", {31'd0, afero_idle_o}, 32'd1);
        tick();
        tick();
        #1;
        chk("spur_err_sticky", {31'd0, err_o}, 32'd1);
        chk("spur_rvalid_late", {31'd0, afero_rvalid_o}, 32'd0);

        // Async reset with one read queued and one in flight.
        afero_req_i  = 1'b1;
        afero_addr_i = 12'h0A4;
        afero_size_i = 2'd1;
        tick();
        afero_req_i = 1'b0;
        udma_gnt_i  = 1'b1;
        tick();
        udma_gnt_i   = 1'b0;
        udma_valid_i = 1'b1;
        udma_data_i  = 32'h44444444;
        tick();
        udma_valid_i = 1'b0;
        afero_req_i  = 1'b1;
        tick();
        afero_req_i = 1'b0;
        #1;
        chk("pre_rst_req", {31'd0, udma_req_o}, 32'd1);
        chk("pre_rst_size", {30'd0, udma_size_o}, 32'd1);
        chk("pre_rst_rvalid", {31'd0, afero_rvalid_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        chk_reset_outputs("arst");
        #2;
        rst_ni = 1'b1;
        tick();
        #1;
        chk("post_rst_idle", {31'd0, afero_idle_o}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
